// File: rtl/spi_peripheral_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_peripheral_pkg                                           |
// | Description : Frame geometry, register map and state type for the SPI      |
// |               control-register peripheral and the PWM stage it feeds.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_peripheral_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    // Bit counter saturates one past a full frame so long frames stay distinguishable
    localparam logic [4:0] c_cnt_frame = 5'd16;
    localparam logic [4:0] c_cnt_max   = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_edge                                                    |
// | Description : Multi-stage synchroniser with history flop and registered    |
// |               rise/fall pulses for one asynchronous input.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_rise;
    logic                   r_fall;

    // r_fill masks the edges that reset-forced idle levels would otherwise fake
    // while the real pin value works its way through the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
            r_fill <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_rise <= r_fill[SYNC_STAGES] &  r_sync[SYNC_STAGES-1] & ~r_hist;
            r_fall <= r_fill[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1] &  r_hist;
        end
    end

    assign o_level = r_hist;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_peripheral                                               |
// | Description : SPI mode-0 receive-only peripheral holding the five 8-bit    |
// |               control registers consumed by the PWM generator.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi_level, w_copi_rise, w_copi_fall;
    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
    logic w_unused_sync;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_din(sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_din(copi),
        .o_level(w_copi_level), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .i_din(ncs),
        .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    assign w_unused_sync = &{w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_level};

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_cnt;
    logic [7:0]            r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
    logic                  r_wr_strobe;
    logic                  w_frame_ok;

    assign w_frame_ok = (r_cnt == c_cnt_frame) && r_shift[FRAME_BITS-1]
                      && (r_shift[14:8] <= MAX_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_en_out_lo <= 8'h00;
            r_en_out_hi <= 8'h00;
            r_en_pwm_lo <= 8'h00;
            r_en_pwm_hi <= 8'h00;
            r_duty      <= 8'h00;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= SHIFT;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Frame end wins over a coincident sclk edge
                    if (w_ncs_rise) begin
                        r_state <= COMMIT;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    if (w_frame_ok) begin
                        r_wr_strobe <= 1'b1;
                        case (r_shift[14:8])
                            ADDR_EN_OUT_7_0:  r_en_out_lo <= r_shift[7:0];
                            ADDR_EN_OUT_15_8: r_en_out_hi <= r_shift[7:0];
                            ADDR_EN_PWM_7_0:  r_en_pwm_lo <= r_shift[7:0];
                            ADDR_EN_PWM_15_8: r_en_pwm_hi <= r_shift[7:0];
                            ADDR_PWM_DUTY:    r_duty      <= r_shift[7:0];
                            default: ;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign wr_strobe       = r_wr_strobe;

endmodule
`default_nettype wire
